// File: rtl/cpu_defs.sv
// Shared op codes, field positions, state encoding and decode flags for the
// cpu control path, its ALU control and benches.
package cpu_defs;

    localparam int OP_LSB   = 12;
    localparam int RD_LSB   = 8;
    localparam int EXT_LSB  = 4;
    localparam int RS_LSB   = 0;
    localparam int IMM8_LSB = 0;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_ADDU  = 4'b0110;
    localparam logic [3:0] OP_ADDC  = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_SUBC  = 4'b1010;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_MOV   = 4'b1101;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

    typedef struct packed {
        logic legal;
        logic use_imm;
        logic pass_b;
        logic flag_we;
        logic is_cmp;
    } ctrl_flags_t;

    function automatic logic is_legal_code(input logic [3:0] c);
        case (c)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC,
            OP_SUB, OP_SUBC, OP_CMP, OP_MOV: is_legal_code = 1'b1;
            default:                         is_legal_code = 1'b0;
        endcase
    endfunction

    // Arithmetic ops both update flags and sign-extend their immediate.
    function automatic logic is_arith(input logic [3:0] c);
        case (c)
            OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: is_arith = 1'b1;
            default:                                          is_arith = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational decode of one instruction word into datapath controls,
// legality and the extended immediate.
module cpu_instr_decode
    import cpu_defs::*;
#(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic [15:0]              ir,
    output logic [3:0]               alu_op,
    output logic [REG_ADDR_BITS-1:0] addr_a,
    output logic [REG_ADDR_BITS-1:0] addr_b,
    output logic [REG_WIDTH-1:0]     imm,
    output ctrl_flags_t              flags
);

    logic [3:0] op;
    logic [3:0] ext;
    logic [7:0] imm8;
    logic       r_type;
    logic       legal;

    always_comb begin
        op     = ir[OP_LSB +: 4];
        ext    = ir[EXT_LSB +: 4];
        imm8   = ir[IMM8_LSB +: 8];
        r_type = (op == OP_RTYPE);
        alu_op = r_type ? ext : op;
        addr_a = ir[RD_LSB +: REG_ADDR_BITS];
        addr_b = ir[RS_LSB +: REG_ADDR_BITS];
        legal  = is_legal_code(alu_op);

        flags         = '0;
        flags.legal   = legal;
        flags.use_imm = legal && !r_type;
        flags.pass_b  = legal && (alu_op == OP_MOV);
        flags.flag_we = legal && is_arith(alu_op);
        flags.is_cmp  = legal && (alu_op == OP_CMP);

        // R-type words reuse imm8 bits as ext/rs, so no immediate is presented.
        imm = '0;
        if (legal && !r_type) begin
            if (is_arith(alu_op))
                imm = {{(REG_WIDTH-8){imm8[7]}}, imm8};
            else
                imm = {{(REG_WIDTH-8){1'b0}}, imm8};
        end
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback controller driving the cpu
// datapath; every output is a flop so the datapath sees glitch-free controls.
module cpu_control_fsm
    import cpu_defs::*;
#(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              instr,
    input  logic                     instrValid,
    output logic                     instrReady,
    output logic [3:0]               aluOpCode,
    output logic [REG_ADDR_BITS-1:0] regAddressA,
    output logic [REG_ADDR_BITS-1:0] regAddressB,
    output logic [REG_WIDTH-1:0]     immediate,
    output logic                     useImmediate,
    output logic                     passB,
    output logic                     regWriteEnable,
    output logic                     flagWriteEnable,
    output logic                     illegalInstr,
    output logic                     pcIncrement
);

    state_t                   state_q, state_d;
    logic [15:0]              ir_q, ir_d;
    logic [3:0]               alu_op_q, alu_op_d;
    logic [REG_ADDR_BITS-1:0] addr_a_q, addr_a_d;
    logic [REG_ADDR_BITS-1:0] addr_b_q, addr_b_d;
    logic [REG_WIDTH-1:0]     imm_q, imm_d;
    ctrl_flags_t              flags_q, flags_d;
    logic                     instr_ready_q, instr_ready_d;
    logic                     reg_we_q, reg_we_d;
    logic                     flag_we_q, flag_we_d;
    logic                     illegal_q, illegal_d;
    logic                     pc_inc_q, pc_inc_d;

    logic [3:0]               dec_alu_op;
    logic [REG_ADDR_BITS-1:0] dec_addr_a;
    logic [REG_ADDR_BITS-1:0] dec_addr_b;
    logic [REG_WIDTH-1:0]     dec_imm;
    ctrl_flags_t              dec_flags;

    // Decoding the word as it is captured lets controls be valid in DECODE.
    cpu_instr_decode #(
        .REG_WIDTH     (REG_WIDTH),
        .REG_ADDR_BITS (REG_ADDR_BITS)
    ) u_decode (
        .ir     (instr),
        .alu_op (dec_alu_op),
        .addr_a (dec_addr_a),
        .addr_b (dec_addr_b),
        .imm    (dec_imm),
        .flags  (dec_flags)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        imm_d     = imm_q;
        flags_d   = flags_q;
        reg_we_d  = 1'b0;
        flag_we_d = 1'b0;
        illegal_d = 1'b0;
        pc_inc_d  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (instr_ready_q && instrValid) begin
                    ir_d      = instr;
                    alu_op_d  = dec_alu_op;
                    addr_a_d  = dec_addr_a;
                    addr_b_d  = dec_addr_b;
                    imm_d     = dec_imm;
                    flags_d   = dec_flags;
                    illegal_d = !dec_flags.legal;
                    pc_inc_d  = !dec_flags.legal;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!flags_q.legal) begin
                    state_d = ST_FETCH;
                end else begin
                    flag_we_d = flags_q.flag_we;
                    pc_inc_d  = flags_q.is_cmp;
                    state_d   = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (flags_q.is_cmp) begin
                    state_d = ST_FETCH;
                end else begin
                    reg_we_d = 1'b1;
                    pc_inc_d = 1'b1;
                    state_d  = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase

        instr_ready_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            ir_q          <= '0;
            alu_op_q      <= '0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            imm_q         <= '0;
            flags_q       <= '0;
            instr_ready_q <= 1'b0;
            reg_we_q      <= 1'b0;
            flag_we_q     <= 1'b0;
            illegal_q     <= 1'b0;
            pc_inc_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            alu_op_q      <= alu_op_d;
            addr_a_q      <= addr_a_d;
            addr_b_q      <= addr_b_d;
            imm_q         <= imm_d;
            flags_q       <= flags_d;
            instr_ready_q <= instr_ready_d;
            reg_we_q      <= reg_we_d;
            flag_we_q     <= flag_we_d;
            illegal_q     <= illegal_d;
            pc_inc_q      <= pc_inc_d;
        end
    end

    assign instrReady      = instr_ready_q;
    assign aluOpCode       = alu_op_q;
    assign regAddressA     = addr_a_q;
    assign regAddressB     = addr_b_q;
    assign immediate       = imm_q;
    assign useImmediate    = flags_q.use_imm;
    assign passB           = flags_q.pass_b;
    assign regWriteEnable  = reg_we_q;
    assign flagWriteEnable = flag_we_q;
    assign illegalInstr    = illegal_q;
    assign pcIncrement     = pc_inc_q;

endmodule
